// File: rtl/mux_sel_pipe.sv
// mux_sel_pipe: registered N-to-1 selector, valid/ready on both sides,
// direct or round-robin scan select, out-of-range select flag.
module mux_sel_pipe #(
  parameter  int N_INP = 32,
  parameter  int W     = 2,
  localparam int SELW  = (N_INP > 1) ? $clog2(N_INP) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_INP*W-1:0] inp,
  input  logic               mode,
  input  logic [SELW-1:0]    sel_i,
  input  logic               sel_valid,
  output logic               sel_ready,
  output logic [W-1:0]       out,
  output logic [SELW-1:0]    out_idx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sel_err
);

  localparam logic [SELW:0]   LIM  = (SELW+1)'(N_INP);
  localparam logic [SELW-1:0] LAST = SELW'(N_INP - 1);

  logic            mode_q;
  logic [SELW-1:0] scan_cnt;
  logic            accept;
  logic            rise;
  logic            oor;
  logic [SELW-1:0] eff_cnt;
  logic [SELW-1:0] nxt_cnt;
  logic [SELW-1:0] idx;
  logic [W-1:0]    pick;

  assign sel_ready = !out_valid | out_ready;
  assign accept    = sel_valid & sel_ready;

  // first scan cycle after direct mode restarts the sweep at channel 0
  assign rise    = mode & !mode_q;
  assign eff_cnt = rise ? '0 : scan_cnt;
  assign nxt_cnt = (eff_cnt == LAST) ? '0 : eff_cnt + SELW'(1);

  assign idx = mode ? eff_cnt : sel_i;
  assign oor = !mode && ({1'b0, sel_i} >= LIM);

  // no match for out-of-range indices, so those beats carry zero
  always_comb begin
    pick = '0;
    for (int k = 0; k < N_INP; k++) begin
      if (idx == SELW'(k)) pick = inp[k*W +: W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
      scan_cnt  <= '0;
      mode_q    <= 1'b0;
    end else begin
      mode_q  <= mode;
      sel_err <= accept & oor;
      if (mode) scan_cnt <= accept ? nxt_cnt : eff_cnt;
      if (accept) begin
        out       <= pick;
        out_idx   <= idx;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_sel_pipe.sv
// tb_mux_sel_pipe: random and directed checks of two mux_sel_pipe
// instances (N_INP=32 and N_INP=20) against a beat-level model.
module tb_mux_sel_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [63:0] inp0;
  logic [39:0] inp1;
  logic        md[2];
  logic        sv[2];
  logic        ordy[2];
  logic [4:0]  sel[2];

  logic       sr0, sr1, ov0, ov1, er0, er1;
  logic [1:0] o0, o1;
  logic [4:0] oi0, oi1;

  mux_sel_pipe #(.N_INP(32), .W(2)) u0 (
    .clk(clk), .rst_n(rst_n), .inp(inp0),
    .mode(md[0]), .sel_i(sel[0]), .sel_valid(sv[0]),
    .sel_ready(sr0), .out(o0), .out_idx(oi0),
    .out_valid(ov0), .out_ready(ordy[0]), .sel_err(er0)
  );

  mux_sel_pipe #(.N_INP(20), .W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .inp(inp1),
    .mode(md[1]), .sel_i(sel[1]), .sel_valid(sv[1]),
    .sel_ready(sr1), .out(o1), .out_idx(oi1),
    .out_valid(ov1), .out_ready(ordy[1]), .sel_err(er1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int mv[2], mo[2], mi[2], me[2];
  int pos[2], pm[2];

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int chan(input int d, input int k);
    if (d == 0) return (k < 32) ? int'(inp0[k*2 +: 2]) : 0;
    return (k < 20) ? int'(inp1[k*2 +: 2]) : 0;
  endfunction

  task automatic check_outs();
    chk("valid0", ov0, mv[0]);
    chk("data0", o0, mo[0]);
    chk("idx0", oi0, mi[0]);
    chk("err0", er0, me[0]);
    chk("valid1", ov1, mv[1]);
    chk("data1", o1, mo[1]);
    chk("idx1", oi1, mi[1]);
    chk("err1", er1, me[1]);
  endtask

  task automatic step();
    int nv[2], no[2], ni[2], ne[2];
    #1;
    chk("rdy0", sr0, int'(mv[0] == 0 || ordy[0]));
    chk("rdy1", sr1, int'(mv[1] == 0 || ordy[1]));
    for (int d = 0; d < 2; d++) begin
      int n;
      int k;
      bit acc;
      n = (d == 0) ? 32 : 20;
      acc = sv[d] && (mv[d] == 0 || ordy[d]);
      nv[d] = mv[d]; no[d] = mo[d]; ni[d] = mi[d]; ne[d] = 0;
      if (acc) begin
        if (md[d]) begin
          k = (pm[d] != 0) ? pos[d] : 0;
          pos[d] = (k + 1) % n;
        end else begin
          k = int'(sel[d]);
        end
        nv[d] = 1;
        ni[d] = k;
        no[d] = chan(d, k);
        ne[d] = int'(!md[d] && k >= n);
      end else begin
        if (md[d] && pm[d] == 0) pos[d] = 0;
        if (mv[d] != 0 && ordy[d]) nv[d] = 0;
      end
      pm[d] = int'(md[d]);
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      mv[d] = nv[d]; mo[d] = no[d]; mi[d] = ni[d]; me[d] = ne[d];
    end
    check_outs();
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mv[d] = 0; mo[d] = 0; mi[d] = 0; me[d] = 0;
      pos[d] = 0; pm[d] = 0;
    end
    #1;
    check_outs();
    chk("rst_rdy0", sr0, 1);
    chk("rst_rdy1", sr1, 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    logic [1:0] v7;
    rst_n = 1'b1;
    inp0 = '0;
    inp1 = {$urandom, $urandom};
    for (int d = 0; d < 2; d++) begin
      md[d] = 1'b0; sv[d] = 1'b0; ordy[d] = 1'b0; sel[d] = '0;
    end
    #7;
    do_reset();

    for (int k = 0; k < 32; k++) inp0[k*2 +: 2] = 2'(k % 4);
    sv[0] = 1'b1; ordy[0] = 1'b1;
    for (int k = 0; k < 32; k++) begin
      sel[0] = 5'(k);
      step();
      chk("sweep_idx", oi0, k);
      chk("sweep_dat", o0, k % 4);
    end
    sv[0] = 1'b0;
    step();

    sv[1] = 1'b1; ordy[1] = 1'b1; sel[1] = 5'd25;
    step();
    chk("oor_err", er1, 1);
    chk("oor_dat", o1, 0);
    chk("oor_idx", oi1, 25);
    sel[1] = 5'd3;
    step();
    chk("ok_err", er1, 0);
    chk("ok_dat", o1, int'(inp1[7:6]));
    sv[1] = 1'b0;
    step();

    md[0] = 1'b1; sv[0] = 1'b1; ordy[0] = 1'b1;
    for (int k = 0; k < 70; k++) begin
      sel[0] = 5'($urandom);
      step();
      chk("scan_seq", oi0, k % 32);
      chk("scan_err", er0, 0);
    end

    md[0] = 1'b0; sel[0] = 5'd7; inp0 = {$urandom, $urandom};
    v7 = inp0[15:14];
    step();
    ordy[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      inp0 = {$urandom, $urandom};
      sel[0] = 5'($urandom);
      step();
      chk("bp_idx", oi0, 7);
      chk("bp_hold", o0, int'(v7));
      chk("bp_rdy", sr0, 0);
    end
    ordy[0] = 1'b1; sel[0] = 5'd9;
    step();
    chk("bp_next", oi0, 9);

    sel[0] = 5'd30;
    repeat (3) step();
    md[0] = 1'b1;
    step();
    chk("sw_first", oi0, 0);
    step();
    chk("sw_second", oi0, 1);
    md[0] = 1'b0; sel[0] = 5'd5;
    step();
    md[0] = 1'b1;
    step();
    chk("sw_again", oi0, 0);

    for (int c = 0; c < 400; c++) begin
      inp0 = {$urandom, $urandom};
      inp1 = {$urandom, $urandom};
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(0, 9) == 0) md[d] = ~md[d];
        sv[d]   = ($urandom_range(0, 3) != 0);
        ordy[d] = ($urandom_range(0, 3) != 0);
        sel[d]  = 5'($urandom_range(0, 31));
      end
      step();
    end

    md[0] = 1'b1; sv[0] = 1'b1; ordy[0] = 1'b1;
    md[1] = 1'b0; sv[1] = 1'b0;
    repeat (4) step();
    ordy[0] = 1'b0;
    step();
    do_reset();
    ordy[0] = 1'b1;
    step();
    chk("rst_scan", oi0, 0);
    step();
    chk("rst_scan2", oi0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
